mem_port_arbiter: RTL and testbench

- Shares the processor's single memory port between two requesters: instruction fetch (F) and data load/store (D).
- Sequences each access through a grant / issue / wait / done handshake.
- Drives the one-bit port-select line that steers the address and data muxes in front of memory.
- Sits between the multicycle control unit and the memory block, and resolves simultaneous requests round-robin.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch/data requester handshakes and the memory-side bus of mem_port_arbiter.
// Latency: none; this is wiring only.
// Backpressure: none; the arbiter's grant and done pulses pace the requesters.
// Ports: slave = arbiter side (takes requests and memRData, drives grants, dones and memory strobes);
//        master = requester/memory side (the mirror image).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              fReq;
   logic [ADDR_W-1:0] fAddr;
   logic              fGnt;
   logic              fDone;
   logic              dReq;
   logic              dWe;
   logic [ADDR_W-1:0] dAddr;
   logic [DATA_W-1:0] dWData;
   logic              dGnt;
   logic              dDone;
   logic [DATA_W-1:0] rData;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData;
   logic              memEn;
   logic              memWe;
   logic [DATA_W-1:0] memRData;
   logic              portSlct;
   logic              busy;

   modport slave (
      input  fReq, fAddr, dReq, dWe, dAddr, dWData, memRData,
      output fGnt, fDone, dGnt, dDone, rData, memAddr, memWData,
             memEn, memWe, portSlct, busy
   );

   modport master (
      output fReq, fAddr, dReq, dWe, dAddr, dWData, memRData,
      input  fGnt, fDone, dGnt, dDone, rData, memAddr, memWData,
             memEn, memWe, portSlct, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between fetch (F) and data (D) requesters.
// Latency: request seen in IDLE at t -> grant t+1, memEn t+2, done/rData t+3+MEM_LAT, IDLE t+4+MEM_LAT.
// Backpressure: one transaction at a time; requests are sampled only in IDLE, so a held request waits.
// Ports: CLK, Reset (sync, active-high); bus = mem_port_arbiter_if.slave carrying the
//        fReq/fAddr/fGnt/fDone, dReq/dWe/dAddr/dWData/dGnt/dDone, rData, mem* and portSlct/busy.
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic                CLK,
   input  logic                Reset,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GRANT  = 3'd1,
      ACCESS = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              last_q;     // 1 = data won the previous arbitration
   logic              sel_q;      // captured winner: 0 = fetch, 1 = data
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        cnt_q;

   logic              take;
   logic              win;

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      win     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.fReq || bus.dReq) begin
               take    = 1'b1;
               // On a tie the side that did not win last time goes first.
               win     = (bus.fReq && bus.dReq) ? ~last_q : bus.dReq;
               state_d = GRANT;
            end
         end
         GRANT:   state_d = ACCESS;
         ACCESS:  state_d = WAIT;
         WAIT:    if (cnt_q == 4'd0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;           // fetch wins the first tie
         sel_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            sel_q   <= win;
            last_q  <= win;
            addr_q  <= win ? bus.dAddr : bus.fAddr;
            // Fetch never writes; its write-data lane is driven to zero.
            wdata_q <= win ? bus.dWData : '0;
            we_q    <= win ? bus.dWe : 1'b0;
         end
         if (state_q == ACCESS) begin
            cnt_q <= 4'(MEM_LAT - 1);
         end else if (state_q == WAIT) begin
            if (cnt_q == 4'd0) begin
               // Memory read data is valid in the last WAIT cycle; writes leave rData alone.
               if (!we_q) rdata_q <= bus.memRData;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
         end
      end
   end

   // All strobes decode from the registered state, so they read as zero in IDLE and after reset.
   assign bus.fGnt     = (state_q == GRANT)  && !sel_q;
   assign bus.dGnt     = (state_q == GRANT)  &&  sel_q;
   assign bus.fDone    = (state_q == DONE)   && !sel_q;
   assign bus.dDone    = (state_q == DONE)   &&  sel_q;
   assign bus.memEn    = (state_q == ACCESS);
   assign bus.memWe    = (state_q == ACCESS) &&  we_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.portSlct = sel_q;
   assign bus.memAddr  = addr_q;
   assign bus.memWData = wdata_q;
   assign bus.rData    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with MEM_LAT=1 and MEM_LAT=3 instances.
// Latency: cycle-accurate checks against hand-computed per-cycle expectations.
// Backpressure: n/a; inputs driven on the falling edge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic CLK   = 1'b0;
   logic Reset = 1'b1;
   always #5 CLK = ~CLK;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u1 (
      .CLK(CLK), .Reset(Reset), .bus(b1.slave));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u3 (
      .CLK(CLK), .Reset(Reset), .bus(b3.slave));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, fr;
      logic [15:0] fa;
      logic        dr, dw;
      logic [15:0] da, dd, mr;
      logic        fg, fd, dg, dn, en, we, busy, sel;
      logic [15:0] ma, mwd, rd;
   } vec_t;

   function automatic vec_t mk(
      input logic rst, input logic fr, input logic [15:0] fa,
      input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
      input logic [15:0] mr,
      input logic fg, input logic fd, input logic dg, input logic dn,
      input logic en, input logic we, input logic busy, input logic sel,
      input logic [15:0] ma, input logic [15:0] mwd, input logic [15:0] rd);
      vec_t v;
      v.rst = rst; v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
      v.fg = fg; v.fd = fd; v.dg = dg; v.dn = dn; v.en = en; v.we = we; v.busy = busy;
      v.sel = sel; v.ma = ma; v.mwd = mwd; v.rd = rd;
      return v;
   endfunction

   localparam int NV = 12;
   vec_t vt [NV];

   initial begin
      b1.fReq = 0; b1.fAddr = 0; b1.dReq = 0; b1.dWe = 0; b1.dAddr = 0; b1.dWData = 0; b1.memRData = 0;
      b3.fReq = 0; b3.fAddr = 0; b3.dReq = 0; b3.dWe = 0; b3.dAddr = 0; b3.dWData = 0; b3.memRData = 0;

      // Rows: one per cycle on the MEM_LAT=1 instance. Fetch read then data write.
      //           rst fr fa        dr dw da        dd        mr         fg fd dg dn en we bz sl ma        mwd       rd
      vt[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      vt[1]  = mk(0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      vt[2]  = mk(0, 0, 16'h0FFF, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'h0000);
      vt[3]  = mk(0, 0, 16'h0FFF, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0040, 16'h0000, 16'h0000);
      vt[4]  = mk(0, 0, 16'h0FFF, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'h0000);
      vt[5]  = mk(0, 0, 16'h0FFF, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'h1234);
      vt[6]  = mk(0, 0, 16'h0000, 1, 1, 16'h0100, 16'hBEEF, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h1234);
      vt[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 1, 0, 0, 0, 1, 1, 16'h0100, 16'hBEEF, 16'h1234);
      vt[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 0, 1, 1, 1, 1, 16'h0100, 16'hBEEF, 16'h1234);
      vt[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h5555, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0100, 16'hBEEF, 16'h1234);
      vt[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0100, 16'hBEEF, 16'h1234);
      vt[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100, 16'hBEEF, 16'h1234);

      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         Reset = vt[i].rst;
         b1.fReq = vt[i].fr; b1.fAddr = vt[i].fa;
         b1.dReq = vt[i].dr; b1.dWe = vt[i].dw; b1.dAddr = vt[i].da; b1.dWData = vt[i].dd;
         b1.memRData = vt[i].mr;
         #1;
         check($sformatf("vec%0d fGnt", i),     32'(b1.fGnt),     32'(vt[i].fg));
         check($sformatf("vec%0d fDone", i),    32'(b1.fDone),    32'(vt[i].fd));
         check($sformatf("vec%0d dGnt", i),     32'(b1.dGnt),     32'(vt[i].dg));
         check($sformatf("vec%0d dDone", i),    32'(b1.dDone),    32'(vt[i].dn));
         check($sformatf("vec%0d memEn", i),    32'(b1.memEn),    32'(vt[i].en));
         check($sformatf("vec%0d memWe", i),    32'(b1.memWe),    32'(vt[i].we));
         check($sformatf("vec%0d busy", i),     32'(b1.busy),     32'(vt[i].busy));
         check($sformatf("vec%0d portSlct", i), 32'(b1.portSlct), 32'(vt[i].sel));
         check($sformatf("vec%0d memAddr", i),  32'(b1.memAddr),  32'(vt[i].ma));
         check($sformatf("vec%0d memWData", i), 32'(b1.memWData), 32'(vt[i].mwd));
         check($sformatf("vec%0d rData", i),    32'(b1.rData),    32'(vt[i].rd));
      end

      // Both requesters held from reset: grants F,D,F,D at cycles 1,6,11,16.
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      b1.fReq = 1; b1.fAddr = 16'h0011; b1.dReq = 1; b1.dWe = 0; b1.dAddr = 16'h0022;
      for (int c = 0; c < 20; c++) begin
         #1;
         check($sformatf("tie c%0d fGnt", c), 32'(b1.fGnt), 32'((c % 5 == 1) && ((c / 5) % 2 == 0)));
         check($sformatf("tie c%0d dGnt", c), 32'(b1.dGnt), 32'((c % 5 == 1) && ((c / 5) % 2 == 1)));
         if (c % 5 == 2)
            check($sformatf("tie c%0d memAddr", c), 32'(b1.memAddr),
                  ((c / 5) % 2 == 0) ? 32'h0011 : 32'h0022);
         @(negedge CLK);
      end
      b1.fReq = 0; b1.dReq = 0;

      // MEM_LAT=3 data read: data valid only in cycle 5, dDone at cycle 6.
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      b3.dReq = 1; b3.dWe = 0; b3.dAddr = 16'h0200;
      for (int c = 0; c < 9; c++) begin
         if (c == 1) b3.dReq = 0;
         b3.memRData = (c == 5) ? 16'hA5A5 : 16'h0BAD;
         #1;
         check($sformatf("lat3 c%0d dGnt", c),  32'(b3.dGnt),  32'(c == 1));
         check($sformatf("lat3 c%0d memEn", c), 32'(b3.memEn), 32'(c == 2));
         check($sformatf("lat3 c%0d dDone", c), 32'(b3.dDone), 32'(c == 6));
         check($sformatf("lat3 c%0d busy", c),  32'(b3.busy),  32'(c >= 1 && c <= 6));
         if (c == 2) check("lat3 memAddr", 32'(b3.memAddr), 32'h0200);
         if (c == 6) check("lat3 rData",   32'(b3.rData),   32'hA5A5);
         @(negedge CLK);
      end

      // Reset during WAIT of a fetch: abandon, then a tie goes to fetch again.
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      b3.fReq = 1; b3.fAddr = 16'h0300; b3.memRData = 16'h7777;
      for (int c = 0; c < 16; c++) begin
         if (c == 1) b3.fReq = 0;
         Reset = (c == 4);
         if (c == 8) begin b3.fReq = 1; b3.dReq = 1; end
         if (c == 9) begin b3.fReq = 0; b3.dReq = 0; end
         #1;
         if (c == 2) check("rstw memEn before reset", 32'(b3.memEn), 32'h1);
         if (c == 5) begin
            check("rstw busy",     32'(b3.busy),     32'h0);
            check("rstw portSlct", 32'(b3.portSlct), 32'h0);
            check("rstw memAddr",  32'(b3.memAddr),  32'h0);
            check("rstw memWData", 32'(b3.memWData), 32'h0);
            check("rstw rData",    32'(b3.rData),    32'h0);
            check("rstw memWe",    32'(b3.memWe),    32'h0);
         end
         if (c >= 5 && c <= 8) begin
            check($sformatf("rstw c%0d fDone", c), 32'(b3.fDone), 32'h0);
            check($sformatf("rstw c%0d dDone", c), 32'(b3.dDone), 32'h0);
            check($sformatf("rstw c%0d memEn", c), 32'(b3.memEn), 32'h0);
         end
         if (c == 9) begin
            check("rstw tie fGnt", 32'(b3.fGnt), 32'h1);
            check("rstw tie dGnt", 32'(b3.dGnt), 32'h0);
         end
         if (c == 14) check("rstw fetch done", 32'(b3.fDone), 32'h1);
         @(negedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
